// File: rtl/job_completion_ring.sv
// Completion writer: pops {pasid,status} entries and posts each as a one-beat AXI write into a per-PASID host ring.
// Optional JOB_CMPL_IRQ_EN adds a per-OKAY-response notification (irq_valid_o / irq_pasid_o).
module job_completion_ring #(
    parameter int ID_WIDTH     = 1,
    parameter int PASID_WIDTH  = 9,
    parameter int STATUS_WIDTH = 32,
    parameter int RETURN_WIDTH = 41,
    parameter int AWUSER_WIDTH = 9,
    parameter int DATA_WIDTH   = 1024,
    parameter int ADDR_WIDTH   = 64,
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_OUTST    = 4,
    parameter int RING_LOG2    = 6
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      cfg_wr_i,
    input  logic                      cfg_hi_i,
    input  logic [PASID_WIDTH-1:0]    cfg_pasid_i,
    input  logic [31:0]               cfg_data_i,
    input  logic                      complete_push_i,
    input  logic [RETURN_WIDTH-1:0]   return_data_i,
    output logic                      complete_ready_o,
    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic [AWUSER_WIDTH-1:0]   m_axi_awuser,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [ID_WIDTH-1:0]       m_axi_wid,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic                      m_axi_bready,
    input  logic                      m_axi_bvalid,
    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    output logic [3:0]                outst_o,
    output logic                      err_o,
    output logic [PASID_WIDTH-1:0]    err_pasid_o,
    output logic [1:0]                err_resp_o
`ifdef JOB_CMPL_IRQ_EN
    ,
    output logic                      irq_valid_o,
    output logic [PASID_WIDTH-1:0]    irq_pasid_o
`endif
);

    localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
    localparam int FIFO_AW   = $clog2(FIFO_DEPTH);
    localparam int NUM_PASID = 1 << PASID_WIDTH;
    localparam int QW        = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOOK, ST_SEND} state_t;

    // ---------------- input FIFO ----------------
    logic [RETURN_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW:0]        wr_ptr_reg, rd_ptr_reg;
    logic                    fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [RETURN_WIDTH-1:0] fifo_head;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = ((wr_ptr_reg - rd_ptr_reg) == (FIFO_AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a push at full is still taken
    assign fifo_push  = complete_push_i && (!fifo_full || fifo_pop);
    assign fifo_head  = fifo_mem[rd_ptr_reg[FIFO_AW-1:0]];
    assign complete_ready_o = !fifo_full;

    always_ff @(posedge clk) begin
        if (fifo_push)
            fifo_mem[wr_ptr_reg[FIFO_AW-1:0]] <= return_data_i;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // ---------------- issue FSM ----------------
    state_t                   state_reg, state_next;
    logic                     aw_pend_reg, aw_pend_next;
    logic                     w_pend_reg, w_pend_next;
    logic [PASID_WIDTH-1:0]   pasid_reg;
    logic [STATUS_WIDTH-1:0]  status_reg;
    logic [ADDR_WIDTH-1:0]    addr_reg, addr_calc;
    logic [3:0]               outst_reg;
    logic                     aw_fire, b_take;

    assign aw_fire = aw_pend_reg && m_axi_awready;
    // A response with nothing outstanding cannot belong to us and is ignored
    assign b_take  = m_axi_bvalid && (outst_reg != 4'd0);

    always_comb begin
        state_next   = state_reg;
        aw_pend_next = aw_pend_reg;
        w_pend_next  = w_pend_reg;
        fifo_pop     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && (outst_reg < 4'(MAX_OUTST))) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_LOOK;
                end
            end
            ST_LOOK: begin
                aw_pend_next = 1'b1;
                w_pend_next  = 1'b1;
                state_next   = ST_SEND;
            end
            ST_SEND: begin
                if (aw_pend_reg && m_axi_awready) aw_pend_next = 1'b0;
                if (w_pend_reg && m_axi_wready)   w_pend_next  = 1'b0;
                if (!aw_pend_next && !w_pend_next) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            aw_pend_reg <= 1'b0;
            w_pend_reg  <= 1'b0;
            pasid_reg   <= '0;
            status_reg  <= '0;
            addr_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            aw_pend_reg <= aw_pend_next;
            w_pend_reg  <= w_pend_next;
            if (fifo_pop) begin
                pasid_reg  <= fifo_head[RETURN_WIDTH-1 -: PASID_WIDTH];
                status_reg <= fifo_head[STATUS_WIDTH-1:0];
            end
            if (state_reg == ST_LOOK)
                addr_reg <= addr_calc;
        end
    end

    // ---------------- base and ring index tables ----------------
    logic [31:0]          base_lo_mem [NUM_PASID];
    logic [31:0]          base_hi_mem [NUM_PASID];
    logic [RING_LOG2-1:0] idx_reg     [NUM_PASID];
    logic [63:0]          base_full;

    always_ff @(posedge clk) begin
        if (cfg_wr_i) begin
            if (cfg_hi_i) base_hi_mem[cfg_pasid_i] <= cfg_data_i;
            else          base_lo_mem[cfg_pasid_i] <= cfg_data_i;
        end
    end

    assign base_full = {base_hi_mem[pasid_reg], base_lo_mem[pasid_reg]};
    assign addr_calc = ADDR_WIDTH'(base_full) + (ADDR_WIDTH'(idx_reg[pasid_reg]) << SIZE_LOG2);

    // The cfg clear is ordered last so it wins over an advance of the same entry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PASID; i++) idx_reg[i] <= '0;
        end else begin
            if (aw_fire)  idx_reg[pasid_reg]   <= idx_reg[pasid_reg] + 1'b1;
            if (cfg_wr_i) idx_reg[cfg_pasid_i] <= '0;
        end
    end

    // ---------------- in-flight pasid queue, counter, errors ----------------
    logic [PASID_WIDTH-1:0] q_mem [MAX_OUTST];
    logic [QW-1:0]          q_wr_reg, q_rd_reg;
    logic [PASID_WIDTH-1:0] q_head;
    logic                   err_reg;
    logic [PASID_WIDTH-1:0] err_pasid_reg;
    logic [1:0]             err_resp_reg;

    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign q_head = q_mem[q_rd_reg];

    always_ff @(posedge clk) begin
        if (aw_fire) q_mem[q_wr_reg] <= pasid_reg;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_wr_reg      <= '0;
            q_rd_reg      <= '0;
            outst_reg     <= '0;
            err_reg       <= 1'b0;
            err_pasid_reg <= '0;
            err_resp_reg  <= '0;
        end else begin
            if (aw_fire) q_wr_reg <= q_inc(q_wr_reg);
            if (b_take)  q_rd_reg <= q_inc(q_rd_reg);
            case ({aw_fire, b_take})
                2'b10:   outst_reg <= outst_reg + 4'd1;
                2'b01:   outst_reg <= outst_reg - 4'd1;
                default: outst_reg <= outst_reg;
            endcase
            if (b_take && (m_axi_bresp != 2'b00) && !err_reg) begin
                err_reg       <= 1'b1;
                err_pasid_reg <= q_head;
                err_resp_reg  <= m_axi_bresp;
            end
        end
    end

`ifdef JOB_CMPL_IRQ_EN
    logic                   irq_valid_reg;
    logic [PASID_WIDTH-1:0] irq_pasid_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_valid_reg <= 1'b0;
            irq_pasid_reg <= '0;
        end else begin
            irq_valid_reg <= b_take && (m_axi_bresp == 2'b00);
            if (b_take && (m_axi_bresp == 2'b00))
                irq_pasid_reg <= q_head;
        end
    end

    assign irq_valid_o = irq_valid_reg;
    assign irq_pasid_o = irq_pasid_reg;
`endif

    // ---------------- AXI outputs ----------------
    logic unused_bid;
    assign unused_bid = ^m_axi_bid;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'(SIZE_LOG2);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awuser  = AWUSER_WIDTH'(pasid_reg);
    assign m_axi_awvalid = aw_pend_reg;
    assign m_axi_wid     = '0;
    assign m_axi_wdata   = DATA_WIDTH'(status_reg);
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = w_pend_reg;
    assign m_axi_wvalid  = w_pend_reg;
    assign m_axi_bready  = 1'b1;

    assign outst_o     = outst_reg;
    assign err_o       = err_reg;
    assign err_pasid_o = err_pasid_reg;
    assign err_resp_o  = err_resp_reg;

endmodule
